// File: rtl/regfile_2r1w.sv
// 2-read/1-write architectural register file; register 0 is hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:1]   wr_en_s;
    logic [DATA_WIDTH-1:0] rd_a_s;
    logic [DATA_WIDTH-1:0] rd_b_s;

    // One-hot write decode; a disabled write yields no enables even with X/Z indices.
    always_comb begin
        wr_en_s = {(NUM_REGS-1){1'b0}};
        if (ctrl_writeEnable == 1'b1) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (ctrl_writeReg == ADDR_WIDTH'(i)) begin
                    wr_en_s[i] = 1'b1;
                end else begin
                    wr_en_s[i] = 1'b0;
                end
            end
        end else begin
            wr_en_s = {(NUM_REGS-1){1'b0}};
        end
    end

    // Storage update: reset clears everything and wins over a coincident write.
    always_ff @(posedge clock) begin
        if (ctrl_reset_n == 1'b0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else begin
            regs_r[0] <= ZERO_DATA;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= data_writeReg;
                end
            end
        end
    end

    // Read port A mux (index 0 reads zero, forwarding only when the bypass build is selected).
    always_comb begin
        rd_a_s = ZERO_DATA;
        if (ctrl_readRegA == ZERO_ADDR) begin
            rd_a_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if ((ctrl_reset_n == 1'b1) && (ctrl_writeEnable == 1'b1) &&
                     (ctrl_writeReg != ZERO_ADDR) && (ctrl_readRegA == ctrl_writeReg)) begin
            rd_a_s = data_writeReg;
`endif
        end else begin
            rd_a_s = regs_r[ctrl_readRegA];
        end
    end

    // Read port B mux, identical in structure to port A.
    always_comb begin
        rd_b_s = ZERO_DATA;
        if (ctrl_readRegB == ZERO_ADDR) begin
            rd_b_s = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if ((ctrl_reset_n == 1'b1) && (ctrl_writeEnable == 1'b1) &&
                     (ctrl_writeReg != ZERO_ADDR) && (ctrl_readRegB == ctrl_writeReg)) begin
            rd_b_s = data_writeReg;
`endif
        end else begin
            rd_b_s = regs_r[ctrl_readRegB];
        end
    end

    assign data_readRegA = rd_a_s;
    assign data_readRegB = rd_b_s;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: reference model plus an expected-value queue
// filled when stimulus is driven and drained when the read ports settle.
module tb_regfile_2r1w;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_errors = 0;

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (ctrl_reset_n === 1'b1 && ctrl_writeEnable === 1'b1 &&
            ctrl_writeReg !== 5'd0 && idx === ctrl_writeReg) return data_writeReg;
`endif
        return model[idx];
    endfunction

    // Drive one cycle's inputs at the negedge and queue the expected read data.
    task automatic drive(input logic rst_n, input logic we, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        @(negedge clock);
        ctrl_reset_n     = rst_n;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wreg;
        data_writeReg    = wdata;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        e.a = exp_read(ra);
        e.b = exp_read(rb);
        exp_q.push_back(e);
    endtask

    // Let the posedge happen and apply the same update to the model.
    task automatic commit();
        logic       rst_n = ctrl_reset_n;
        logic       we    = ctrl_writeEnable;
        logic [4:0] wreg  = ctrl_writeReg;
        logic [31:0] wd   = data_writeReg;
        @(posedge clock);
        if (rst_n === 1'b0) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we === 1'b1 && wreg !== 5'd0) begin
            model[wreg] = wd;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b0, 1'b1, 5'd4, 32'h1111_2222, 5'd0, 5'd0);
        void'(exp_q.pop_front());
        commit();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_readRegA !== e.a || data_readRegB !== e.b || e.a !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_sweep[%0d]: A=%h B=%h expected A=%h B=%h", i,
                         data_readRegA, data_readRegB, e.a, e.b);
            end
            commit();
        end
    endtask

    task automatic test_write();
        exp_t e;
        drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        void'(exp_q.pop_front());
        commit();
        drive(1'b1, 1'b0, 5'd5, 32'd0, 5'd5, 5'd5);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== 32'hDEAD_BEEF || data_readRegB !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL write_r5: A=%h B=%h expected %h", data_readRegA, data_readRegB, e.a);
        end
        commit();
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_readRegA !== e.a || data_readRegB !== e.b) begin
                n_errors++;
                $display("FAIL write_others[%0d]: A=%h B=%h expected A=%h B=%h", i,
                         data_readRegA, data_readRegB, e.a, e.b);
            end
            commit();
        end
    endtask

    task automatic test_r0();
        exp_t e;
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== e.a || data_readRegB !== e.b) begin
            n_errors++;
            $display("FAIL r0_same_cycle: A=%h B=%h expected %h", data_readRegA, data_readRegB, e.a);
        end
        commit();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== 32'd0 || data_readRegB !== e.b) begin
            n_errors++;
            $display("FAIL r0_write_ignored: A=%h B=%h expected 00000000", data_readRegA, data_readRegB);
        end
        commit();
    endtask

    task automatic test_no_write();
        exp_t e;
        drive(1'b1, 1'b1, 5'd7, 32'hCAFE_0007, 5'd0, 5'd0);
        void'(exp_q.pop_front());
        commit();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
            void'(exp_q.pop_front());
            commit();
        end
        // Unknown write index and data while disabled must leave storage intact.
        drive(1'b1, 1'b0, 5'bxxxxx, 32'hxxxx_xxxx, 5'd7, 5'd5);
        void'(exp_q.pop_front());
        commit();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== 32'hCAFE_0007 || data_readRegB !== 32'hDEAD_BEEF ||
            data_readRegA !== e.a || data_readRegB !== e.b) begin
            n_errors++;
            $display("FAIL no_write_hold: A=%h B=%h expected A=%h B=%h",
                     data_readRegA, data_readRegB, e.a, e.b);
        end
        commit();
    endtask

    task automatic test_same_cycle();
        exp_t        e;
        logic [31:0] same_exp;
`ifdef REGFILE_BYPASS_EN
        same_exp = 32'h2;
`else
        same_exp = 32'h1;
`endif
        drive(1'b1, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        void'(exp_q.pop_front());
        commit();
        drive(1'b1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== same_exp || data_readRegA !== e.a || data_readRegB !== 32'd0) begin
            n_errors++;
            $display("FAIL same_cycle_r9: A=%h B=%h expected A=%h B=00000000",
                     data_readRegA, data_readRegB, same_exp);
        end
        commit();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== 32'h2 || data_readRegB !== 32'h2) begin
            n_errors++;
            $display("FAIL next_cycle_r9: A=%h B=%h expected 00000002", data_readRegA, data_readRegB);
        end
        commit();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (c % 4 == 0) ctrl_readRegB = ctrl_writeReg;
            e = exp_q.pop_back();
            e.b = exp_read(ctrl_readRegB);
            exp_q.push_back(e);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_readRegA !== e.a || data_readRegB !== e.b) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: A=%h B=%h expected A=%h B=%h", c,
                         data_readRegA, data_readRegB, e.a, e.b);
            end
            commit();
        end
    endtask

    task automatic test_reset_vs_write();
        exp_t e;
        drive(1'b1, 1'b1, 5'd3, 32'hAA, 5'd0, 5'd0);
        void'(exp_q.pop_front());
        commit();
        drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
        void'(exp_q.pop_front());
        commit();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_readRegA !== 32'd0 || data_readRegB !== 32'd0 ||
            data_readRegA !== e.a || data_readRegB !== e.b) begin
            n_errors++;
            $display("FAIL reset_beats_write: A=%h B=%h expected 00000000",
                     data_readRegA, data_readRegB);
        end
        commit();
    endtask

    initial begin
        ctrl_reset_n     = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'hxxxx_xxxx;
        test_reset();
        test_write();
        test_r0();
        test_no_write();
        test_same_cycle();
        test_back_to_back();
        test_reset_vs_write();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
